// File: rtl/life_game_step_engine.sv
// Conway's Game of Life generation engine for a double-buffered world device.
// Each step reads every cell's 3x3 toroidal neighbourhood from the displayed
// world, writes the next state into the hidden world, then flips the display.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; bus quiet
// S_READ  | 9 cycles presenting neighbourhood addresses k=0..8
// S_WAIT  | captures the offset-8 read data; prepares the cell write
// S_WRITE | writes the next state of cell (y,x) to the hidden world
// S_FLIP  | writes ~world_index to WORLD_INDEX_ADDRESS to swap worlds
// S_DONE  | one-cycle completion pulse
module life_game_step_engine #(
  parameter int          CELL_COUNT_X        = 64,
  parameter int          CELL_COUNT_Y        = 48,
  parameter logic [11:0] WORLD_INDEX_ADDRESS = 12'hFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        cell_write,
  output logic [11:0] cell_address,
  output logic [31:0] cell_data_out,
  input  logic [31:0] cell_data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation_count
);

  localparam logic [5:0] X_LAST = 6'(CELL_COUNT_X - 1);
  localparam logic [5:0] Y_LAST = 6'(CELL_COUNT_Y - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FLIP,
    S_DONE
  } state_t;

  state_t     state;
  logic [5:0] pos_x;
  logic [5:0] pos_y;
  logic [3:0] k_idx;
  logic [3:0] nb_count;
  logic       self_alive;
  logic       world_index;

  logic [3:0] count_final;
  logic       next_alive;
  logic       unused_data_in;

  // Address of neighbourhood offset k around (cy,cx), wrapping on both axes.
  function automatic logic [11:0] nb_addr(input logic [5:0] cy,
                                          input logic [5:0] cx,
                                          input logic [3:0] k);
    logic [5:0] ay;
    logic [5:0] ax;
    if (k < 4'd3)
      ay = (cy == 6'd0) ? Y_LAST : cy - 6'd1;
    else if (k < 4'd6)
      ay = cy;
    else
      ay = (cy == Y_LAST) ? 6'd0 : cy + 6'd1;
    case (k)
      4'd0, 4'd3, 4'd6: ax = (cx == 6'd0) ? X_LAST : cx - 6'd1;
      4'd1, 4'd4, 4'd7: ax = cx;
      default:          ax = (cx == X_LAST) ? 6'd0 : cx + 6'd1;
    endcase
    return {ay, ax};
  endfunction

  // The offset-8 sample arrives in S_WAIT, so fold it in before applying the rule.
  assign count_final    = nb_count + {3'b000, cell_data_in[0]};
  assign next_alive     = (count_final == 4'd3) | (self_alive & (count_final == 4'd2));
  assign unused_data_in = ^cell_data_in[31:1];

  // Step sequencer with registered bus and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      pos_x            <= 6'd0;
      pos_y            <= 6'd0;
      k_idx            <= 4'd0;
      nb_count         <= 4'd0;
      self_alive       <= 1'b0;
      world_index      <= 1'b0;
      cell_write       <= 1'b0;
      cell_address     <= 12'd0;
      cell_data_out    <= 32'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      generation_count <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cell_write    <= 1'b0;
          cell_address  <= 12'd0;
          cell_data_out <= 32'd0;
          if (start) begin
            state        <= S_READ;
            pos_x        <= 6'd0;
            pos_y        <= 6'd0;
            k_idx        <= 4'd0;
            nb_count     <= 4'd0;
            self_alive   <= 1'b0;
            busy         <= 1'b1;
            cell_address <= nb_addr(6'd0, 6'd0, 4'd0);
          end
        end
        S_READ: begin
          // Data on the bus now belongs to the offset presented last cycle.
          if (k_idx != 4'd0) begin
            if (k_idx == 4'd5)
              self_alive <= cell_data_in[0];
            else
              nb_count <= nb_count + {3'b000, cell_data_in[0]};
          end
          if (k_idx == 4'd8) begin
            state <= S_WAIT;
          end else begin
            k_idx        <= k_idx + 4'd1;
            cell_address <= nb_addr(pos_y, pos_x, k_idx + 4'd1);
          end
        end
        S_WAIT: begin
          state         <= S_WRITE;
          cell_write    <= 1'b1;
          cell_address  <= {pos_y, pos_x};
          cell_data_out <= {31'd0, next_alive};
        end
        S_WRITE: begin
          cell_write    <= 1'b0;
          cell_data_out <= 32'd0;
          k_idx         <= 4'd0;
          nb_count      <= 4'd0;
          self_alive    <= 1'b0;
          if (pos_x == X_LAST) begin
            pos_x <= 6'd0;
            if (pos_y == Y_LAST) begin
              state         <= S_FLIP;
              pos_y         <= 6'd0;
              cell_write    <= 1'b1;
              cell_address  <= WORLD_INDEX_ADDRESS;
              cell_data_out <= {31'd0, ~world_index};
            end else begin
              state        <= S_READ;
              pos_y        <= pos_y + 6'd1;
              cell_address <= nb_addr(pos_y + 6'd1, 6'd0, 4'd0);
            end
          end else begin
            state        <= S_READ;
            pos_x        <= pos_x + 6'd1;
            cell_address <= nb_addr(pos_y, pos_x + 6'd1, 4'd0);
          end
        end
        S_FLIP: begin
          state            <= S_DONE;
          world_index      <= ~world_index;
          cell_write       <= 1'b0;
          cell_address     <= 12'd0;
          cell_data_out    <= 32'd0;
          busy             <= 1'b0;
          done             <= 1'b1;
          generation_count <= generation_count + 16'd1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/life_game_step_engine.md
LIFE_GAME_STEP_ENGINE -- requirements
Module: life_game_step_engine

Interface
REQ-001 SHALL have parameter CELL_COUNT_X, default 64, cells per row (x address 6 bits).
REQ-002 SHALL have parameter CELL_COUNT_Y, default 48, rows per world (y address 6 bits).
REQ-003 SHALL have parameter WORLD_INDEX_ADDRESS, default 12'hFFF, cell-bus address that selects the displayed world.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request one generation step; sampled only in IDLE.
REQ-008 cell_write  output  1  cell-bus write strobe to the world device.
REQ-009 cell_address  output  12  cell-bus address {Y[5:0], X[5:0]}.
REQ-010 cell_data_out  output  32  cell-bus write data; only bit 0 is meaningful, bits 31:1 always 0.
REQ-011 cell_data_in  input  32  cell-bus read data from the device (current world); bit 0 = cell state.
REQ-012 busy  output  1  high while a generation step is in progress.
REQ-013 done  output  1  one-cycle pulse when a step has completed.
REQ-014 generation_count  output  16  number of completed steps; wraps 16'hFFFF -> 0.

Function
REQ-015 Bus contract: reads hit the currently displayed world; read data is valid on cell_data_in[0] the cycle after the address is presented; writes with cell_write=1 go to the next (hidden) world; a write to WORLD_INDEX_ADDRESS sets the displayed world to cell_data_out[0].
REQ-016 SHALL keep an internal world_index register mirroring the device's displayed world; reset 0.
REQ-017 States: IDLE, READ, WAIT, WRITE, FLIP, DONE; IDLE --start--> READ with cell (y,x)=(0,0); start in any other state SHALL be ignored.
REQ-018 READ SHALL last exactly 9 cycles, presenting neighbourhood offsets k=0..8 in row-major order: (y-1,x-1),(y-1,x),(y-1,x+1),(y,x-1),(y,x),(y,x+1),(y+1,x-1),(y+1,x),(y+1,x+1); cell_write=0.
REQ-019 Data returned for offset k SHALL be captured in the cycle after offset k is presented; the offset-8 data SHALL be captured in the single WAIT cycle.
REQ-020 Offset k=4 (centre) SHALL set self; all other offsets SHALL add to a 4-bit neighbour count (0..8), cleared at READ entry.
REQ-021 Toroidal wrap: x-1 at x=0 gives 63; x+1 at x=63 gives 0; y-1 at y=0 gives CELL_COUNT_Y-1 (47); y+1 at y=47 gives 0.
REQ-022 WRITE (1 cycle): cell_write=1, cell_address={y,x}, cell_data_out[0] = (count==3) | (self & count==2).
REQ-023 After WRITE: x increments; at x=63, x wraps to 0 and y increments; after cell (47,63) go to FLIP, otherwise back to READ.
REQ-024 FLIP (1 cycle): cell_write=1, cell_address=WORLD_INDEX_ADDRESS, cell_data_out[0]=~world_index; world_index toggles on the same edge.
REQ-025 DONE (1 cycle): done=1, generation_count increments, then IDLE.
REQ-026 busy SHALL be 1 in READ/WAIT/WRITE/FLIP and 0 in IDLE/DONE; one step SHALL take 3072*11+1 = 33793 busy cycles.
REQ-027 In IDLE and DONE: cell_write=0, cell_address=0, cell_data_out=0.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, cell_write=0, cell_address=0, cell_data_out=0, busy=0, done=0, generation_count=0, world_index=0.
REQ-029 Reset mid-step SHALL abandon the step with no FLIP write; partially written hidden-world cells are not restored, and the world device SHALL be re-initialised together with the engine.

Verification
REQ-030 Reset: drive reset_n=0 asynchronously mid-cycle -> all outputs 0 before the next edge; state IDLE.
REQ-031 Blinker with device model: cells (10,5),(10,6),(10,7) alive, pulse start -> busy high 33793 cycles, hidden world holds only (9,6),(10,6),(11,6), FLIP writes 12'hFFF with data 1, done high 1 cycle, generation_count=1.
REQ-032 Corner wrap: cells (0,0),(0,63),(47,0) alive -> after one step (47,63) is also alive and the three originals survive (2x2 block across the corner).
REQ-033 Address order: first step, first 9 addresses SHALL be {47,63},{47,0},{47,1},{0,63},{0,0},{0,1},{1,63},{1,0},{1,1}, then a write to {0,0}.
REQ-034 Start while busy: assert start repeatedly during a step -> no effect; a second start from IDLE runs step 2, FLIP data 0, generation_count=2.
REQ-035 Reset mid-READ at cell (20,30) -> no write to 12'hFFF, generation_count=0, the next start begins at cell (0,0) with world_index 0.
